// File: rtl/usrt_pkg.sv
// Shared USRT definitions: frame sequencer states and bit counter width.
// Used by the transmit sequencer, the counter logic and the receive side.
package usrt_pkg;

    localparam int unsigned CNT_W = 6;

    typedef enum logic [2:0] {
        StIdle,
        StWaitRts,
        StStart,
        StData,
        StParity,
        StStop
    } usrt_state_e;

endpackage

// File: rtl/usrt_shift_reg.sv
// Parallel-load, shift-right register presenting the LSB as the next serial bit.
module usrt_shift_reg #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] din,
    output logic              lsb
);

    logic [DATA_W-1:0] sr_q;

    // Load wins over shift; zeros fill from the top.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q <= '0;
        end else if (load) begin
            sr_q <= din;
        end else if (shift) begin
            sr_q <= {1'b0, sr_q[DATA_W-1:1]};
        end
    end

    assign lsb = sr_q[0];

endmodule

// File: rtl/usrt_tx_seq.sv
// USRT transmit frame sequencer: accepts a word, waits for RTS, then sends
// start, data (LSB first), optional parity and stop bit(s), one per en_usrt.
module usrt_tx_seq
    import usrt_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_usrt,
    input  logic              RTS,
    input  logic              par_en,
    input  logic              par_odd,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              txd,
    output logic              busy,
    output logic [CNT_W-1:0]  bit_cnt,
    output logic              frame_done
);

    localparam logic [CNT_W-1:0] LastBit  = CNT_W'(DATA_W - 1);
    localparam logic             LastStop = 1'(STOP_BITS - 1);

    usrt_state_e      state_q, state_d;
    logic             txd_q, txd_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             stop_cnt_q, stop_cnt_d;
    logic             par_en_q, par_en_d;
    logic             par_bit_q, par_bit_d;
    logic             sr_load, sr_shift, sr_lsb;

    usrt_shift_reg #(
        .DATA_W (DATA_W)
    ) u_shift_reg (
        .clk   (clk),
        .rst   (rst),
        .load  (sr_load),
        .shift (sr_shift),
        .din   (data_in),
        .lsb   (sr_lsb)
    );

    always_comb begin
        state_d    = state_q;
        txd_d      = txd_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        sr_load    = 1'b0;
        sr_shift   = 1'b0;
        frame_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Accept does not wait for en_usrt; parity is fixed from the accepted word.
                if (data_valid) begin
                    sr_load   = 1'b1;
                    par_en_d  = par_en;
                    par_bit_d = par_odd ? ~^data_in : ^data_in;
                    state_d   = StWaitRts;
                end
            end
            StWaitRts: begin
                if (en_usrt && RTS) begin
                    txd_d   = 1'b0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (en_usrt) begin
                    txd_d     = sr_lsb;
                    sr_shift  = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = StData;
                end
            end
            StData: begin
                if (en_usrt) begin
                    if (bit_cnt_q == LastBit) begin
                        bit_cnt_d = '0;
                        if (par_en_q) begin
                            txd_d   = par_bit_q;
                            state_d = StParity;
                        end else begin
                            txd_d   = 1'b1;
                            state_d = StStop;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        txd_d     = sr_lsb;
                        sr_shift  = 1'b1;
                    end
                end
            end
            StParity: begin
                if (en_usrt) begin
                    txd_d   = 1'b1;
                    state_d = StStop;
                end
            end
            StStop: begin
                if (en_usrt) begin
                    if (stop_cnt_q == LastStop) begin
                        stop_cnt_d = 1'b0;
                        frame_done = 1'b1;
                        state_d    = StIdle;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: begin
                txd_d   = 1'b1;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            txd_q      <= 1'b1;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            txd_q      <= txd_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
        end
    end

    assign txd        = txd_q;
    assign bit_cnt    = bit_cnt_q;
    assign busy       = (state_q != StIdle);
    assign data_ready = (state_q == StIdle);

endmodule

// File: tb/tb_usrt_tx_seq.sv
// Directed bench for usrt_tx_seq: one instance with one stop bit, one with two.
module tb_usrt_tx_seq;

    logic       clk;
    logic       rst;
    logic       en_usrt, RTS, par_en, par_odd, data_valid;
    logic [7:0] data_in;
    logic       data_ready, txd, busy, frame_done;
    logic [5:0] bit_cnt;

    logic       b_en, b_valid;
    logic [7:0] b_data;
    logic       b_ready, b_txd, b_busy, b_done;
    logic [5:0] b_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int fd_total = 0;
    int b_acc    = 0;

    usrt_tx_seq #(
        .DATA_W    (8),
        .STOP_BITS (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en_usrt    (en_usrt),
        .RTS        (RTS),
        .par_en     (par_en),
        .par_odd    (par_odd),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .txd        (txd),
        .busy       (busy),
        .bit_cnt    (bit_cnt),
        .frame_done (frame_done)
    );

    usrt_tx_seq #(
        .DATA_W    (8),
        .STOP_BITS (2)
    ) dut2 (
        .clk        (clk),
        .rst        (rst),
        .en_usrt    (b_en),
        .RTS        (1'b1),
        .par_en     (1'b0),
        .par_odd    (1'b0),
        .data_in    (b_data),
        .data_valid (b_valid),
        .data_ready (b_ready),
        .txd        (b_txd),
        .busy       (b_busy),
        .bit_cnt    (b_cnt),
        .frame_done (b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_done) fd_total <= fd_total + 1;
        if (b_valid && b_ready) b_acc <= b_acc + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One bit period with en_usrt every second clk; returns during the enabled clk.
    task automatic period();
        @(negedge clk) en_usrt = 1'b0;
        @(negedge clk) en_usrt = 1'b1;
        #1;
    endtask

    task automatic accept_word(input logic [7:0] d, input logic pe, input logic po);
        @(negedge clk);
        en_usrt    = 1'b0;
        data_in    = d;
        par_en     = pe;
        par_odd    = po;
        data_valid = 1'b1;
        @(negedge clk) data_valid = 1'b0;
        #1;
        check_eq("acc_busy", 32'(busy), 32'd1);
        check_eq("acc_ready", 32'(data_ready), 32'd0);
        check_eq("acc_txd", 32'(txd), 32'd1);
    endtask

    // Leaves WAIT_RTS, then samples txd for nper periods. mod_at >= 0 flips
    // par_en/par_odd/data_in at that period and drops RTS two periods later.
    task automatic run_frame(input string tag, input int nper, input logic [15:0] exp_bits,
                             input int mod_at);
        logic [15:0] got;
        int fd_before, bc_err, fd_err, exp_bc;
        got       = '0;
        bc_err    = 0;
        fd_err    = 0;
        fd_before = fd_total;
        period();
        for (int p = 0; p < nper; p++) begin
            @(negedge clk) en_usrt = 1'b0;
            if (mod_at >= 0 && p == mod_at) begin
                par_en  = ~par_en;
                par_odd = ~par_odd;
                data_in = ~data_in;
            end
            if (mod_at >= 0 && p == mod_at + 2) RTS = 1'b0;
            @(negedge clk) en_usrt = 1'b1;
            #1;
            got[p] = txd;
            exp_bc = (p >= 1 && p <= 8) ? p - 1 : 0;
            if (32'(bit_cnt) != exp_bc) bc_err++;
            if (frame_done != (p == nper - 1)) fd_err++;
        end
        @(negedge clk) en_usrt = 1'b0;
        #1;
        check_eq({tag, "_bits"}, 32'(got), 32'(exp_bits));
        check_eq({tag, "_fd_cnt"}, 32'(fd_total - fd_before), 32'd1);
        check_eq({tag, "_fd_pos_err"}, 32'(fd_err), 32'd0);
        check_eq({tag, "_bitcnt_err"}, 32'(bc_err), 32'd0);
        check_eq({tag, "_busy_after"}, 32'(busy), 32'd0);
        check_eq({tag, "_ready_after"}, 32'(data_ready), 32'd1);
    endtask

    initial begin
        int          err;
        int          fd_snap;
        logic [26:0] seq_txd, seq_fd, seq_rdy;

        rst        = 1'b1;
        en_usrt    = 1'b0;
        RTS        = 1'b1;
        par_en     = 1'b0;
        par_odd    = 1'b0;
        data_in    = '0;
        data_valid = 1'b0;
        b_en       = 1'b0;
        b_valid    = 1'b0;
        b_data     = '0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_txd", 32'(txd), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_ready", 32'(data_ready), 32'd1);
        check_eq("rst_bitcnt", 32'(bit_cnt), 32'd0);
        check_eq("rst_fd", 32'(frame_done), 32'd0);
        check_eq("rst_txd2", 32'(b_txd), 32'd1);
        @(negedge clk) rst = 1'b0;

        // A5, no parity: 0,1,0,1,0,0,1,0,1,1
        accept_word(8'hA5, 1'b0, 1'b0);
        run_frame("t1", 10, 16'h034A, -1);

        // 07 with even then odd parity
        accept_word(8'h07, 1'b1, 1'b0);
        run_frame("t2_even", 11, 16'h060E, -1);
        accept_word(8'h07, 1'b1, 1'b1);
        run_frame("t2_odd", 11, 16'h040E, -1);

        // RTS low for 20 periods: line idle, still busy
        RTS = 1'b0;
        accept_word(8'h3C, 1'b0, 1'b0);
        err = 0;
        for (int i = 0; i < 20; i++) begin
            period();
            if (txd !== 1'b1 || busy !== 1'b1) err++;
        end
        check_eq("t3_hold_err", 32'(err), 32'd0);
        check_eq("t3_hold_bitcnt", 32'(bit_cnt), 32'd0);
        @(negedge clk);
        en_usrt = 1'b0;
        RTS     = 1'b1;
        run_frame("t3", 10, 16'h0278, -1);

        // 5A odd parity; par/data flipped at DATA bit 1, RTS dropped at DATA bit 3
        accept_word(8'h5A, 1'b1, 1'b1);
        run_frame("t4", 11, 16'h06B4, 2);
        RTS     = 1'b1;
        par_en  = 1'b0;
        par_odd = 1'b0;

        // Reset during DATA bit 4
        fd_snap = fd_total;
        accept_word(8'hFF, 1'b0, 1'b0);
        period();
        for (int i = 0; i < 5; i++) period();
        @(negedge clk) en_usrt = 1'b0;
        #1;
        check_eq("t5_pre_bitcnt", 32'(bit_cnt), 32'd4);
        rst = 1'b1;
        #1;
        check_eq("t5_rst_txd", 32'(txd), 32'd1);
        check_eq("t5_rst_busy", 32'(busy), 32'd0);
        check_eq("t5_rst_bitcnt", 32'(bit_cnt), 32'd0);
        check_eq("t5_rst_fd", 32'(frame_done), 32'd0);
        @(negedge clk) rst = 1'b0;
        check_eq("t5_no_fd", 32'(fd_total - fd_snap), 32'd0);
        accept_word(8'hA5, 1'b0, 1'b0);
        run_frame("t5_next", 10, 16'h034A, -1);

        // Two stop bits, en_usrt held high, two words back-to-back
        seq_txd = '0;
        seq_fd  = '0;
        seq_rdy = '0;
        for (int n = 0; n <= 26; n++) begin
            @(negedge clk);
            if (n == 0) begin
                b_en    = 1'b1;
                b_data  = 8'h81;
                b_valid = 1'b1;
            end else if (b_acc == 1) begin
                b_data = 8'h42;
            end else if (b_acc >= 2) begin
                b_valid = 1'b0;
            end
            #1;
            seq_txd[n] = b_txd;
            seq_fd[n]  = b_done;
            seq_rdy[n] = b_ready;
        end
        b_en = 1'b0;
        check_eq("t6_txd_seq", 32'(seq_txd), 32'h7427C0B);
        check_eq("t6_fd_seq", 32'(seq_fd), 32'h2001000);
        check_eq("t6_ready_seq", 32'(seq_rdy), 32'h4002001);
        check_eq("t6_words", 32'(b_acc), 32'd2);
        check_eq("t6_busy_after", 32'(b_busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
